// File: rtl/cordic_seq_if.sv
// Job-side interface of the CORDIC sequencer.
// The master (job source) drives start and the x/y/z operands and watches
// ready/done and the held results; the slave is cordic_seq.
//   start, x_in, y_in, z_in   master -> slave
//   ready, done               slave -> master
//   x_out, y_out, z_out       slave -> master, held until the next accepted job
//   mode                      master -> slave, only when CORDIC_VECTORING_EN is defined
interface cordic_seq_if #(
    parameter int WIDTH = 18
) ();
    logic                    start;
    logic                    ready;
    logic                    done;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic signed [WIDTH-1:0] z_in;
    logic signed [WIDTH-1:0] x_out;
    logic signed [WIDTH-1:0] y_out;
    logic signed [WIDTH-1:0] z_out;
`ifdef CORDIC_VECTORING_EN
    logic                    mode;

    modport master (output start, x_in, y_in, z_in, mode,
                    input  ready, done, x_out, y_out, z_out);
    modport slave  (input  start, x_in, y_in, z_in, mode,
                    output ready, done, x_out, y_out, z_out);
`else
    modport master (output start, x_in, y_in, z_in,
                    input  ready, done, x_out, y_out, z_out);
    modport slave  (input  start, x_in, y_in, z_in,
                    output ready, done, x_out, y_out, z_out);
`endif
endinterface

// File: rtl/cordic_seq.sv
// Iterative CORDIC sequencer driving a combinational arctan LUT.
// One (x,y,z) job is accepted in IDLE; count walks the LUT index 0..ITER-1,
// one shift-add micro-rotation per clock, then done pulses for one cycle
// with the results held on x_out/y_out/z_out.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   job    cordic_seq_if.slave: start/ready/done handshake, operands, results
//   count  registered LUT index
//   angle  atan(2^-count) from the LUT, Q2.16
// Optional feature: define CORDIC_VECTORING_EN to add job.mode
// (0 = rotation, 1 = vectoring), sampled at acceptance.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// ROT   | one micro-rotation per cycle, count = iteration index
// DONE  | done=1 for one cycle, results valid
module cordic_seq #(
    parameter int WIDTH = 18,
    parameter int ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    cordic_seq_if.slave             job,
    output logic [3:0]              count,
    input  logic signed [WIDTH-1:0] angle
);
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ITER - 1);

    state_t                  state;
    state_t                  state_next;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;
    logic signed [WIDTH-1:0] x_next;
    logic signed [WIDTH-1:0] y_next;
    logic signed [WIDTH-1:0] z_next;
    logic                    rot_pos;
    logic                    last;

    assign last = (count == LAST);
    assign x_sh = x >>> count;
    assign y_sh = y >>> count;

`ifdef CORDIC_VECTORING_EN
    logic mode_q;
    // Vectoring steers y toward zero; rotation steers z toward zero.
    assign rot_pos = mode_q ? y[WIDTH-1] : ~z[WIDTH-1];
`else
    assign rot_pos = ~z[WIDTH-1];
`endif

    always_comb begin
        if (rot_pos) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - angle;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + angle;
        end
    end

    always_comb begin
        state_next = state;
        job.ready  = 1'b0;
        job.done   = 1'b0;
        case (state)
            IDLE: begin
                job.ready = 1'b1;
                if (job.start) state_next = ROT;
            end
            ROT:     if (last) state_next = DONE;
            DONE: begin
                job.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            job.x_out <= '0;
            job.y_out <= '0;
            job.z_out <= '0;
`ifdef CORDIC_VECTORING_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (job.start) begin
                        x     <= job.x_in;
                        y     <= job.y_in;
                        z     <= job.z_in;
                        count <= '0;
`ifdef CORDIC_VECTORING_EN
                        mode_q <= job.mode;
`endif
                    end
                end
                ROT: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    if (last) begin
                        count     <= '0;
                        // Results are captured on entry to DONE so they are
                        // already valid in the cycle done is high.
                        job.x_out <= x_next;
                        job.y_out <= y_next;
                        job.z_out <= z_next;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
